// File: rtl/regfile_pkg.sv
// Shared constants and the pending-bit next-state rule for the register file scoreboard.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // Set wins over clear: a retiring producer and a new reservation on the
    // same register in one cycle leave the register pending.
    function automatic logic pend_next(input logic cur, input logic clr, input logic set);
        return set | (cur & ~clr);
    endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback side bus of the register file: read, write and reserve channels.
interface regfile_scoreboard_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              rd_busy1;
    logic              rd_busy2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic [ADDR_W:0]   pend_cnt;

    modport master (
        output rd_en, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rd_data1, rd_data2, rd_busy1, rd_busy2, pend_cnt
    );

    modport slave (
        input  rd_en, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rd_data1, rd_data2, rd_busy1, rd_busy2, pend_cnt
    );
endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending bits with reserve/release and an incrementally maintained population count.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_ok,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              rsv_ok,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              rel_busy1,
    output logic              rel_busy2,
    output logic [ADDR_W:0]   pend_cnt
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [DEPTH-1:0] pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             inc, dec;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            pend_d[i] = pend_next(pend_q[i],
                                  wr_ok  && (wr_addr  == ADDR_W'(i)),
                                  rsv_ok && (rsv_addr == ADDR_W'(i)));
        end

        // A release on the address being reserved is cancelled by the set-wins rule.
        inc = rsv_ok && !pend_q[rsv_addr];
        dec = wr_ok && pend_q[wr_addr] && !(rsv_ok && (rsv_addr == wr_addr));

        cnt_d = cnt_q;
        if (inc && !dec) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec && !inc) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Busy as seen by a reader: this cycle's release applies, this cycle's reserve does not.
    assign rel_busy1 = pend_q[rd_addr1] && !(wr_ok && (wr_addr == rd_addr1));
    assign rel_busy2 = pend_q[rd_addr2] && !(wr_ok && (wr_addr == rd_addr2));
    assign pend_cnt  = cnt_q;

    // NOTE: sequential state is updated with non-blocking assignments only;
    // all next-state logic lives in the always_comb above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// 2R/1W register file with registered reads, write-to-read bypass and a pending-write scoreboard.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_scoreboard_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DATA_W-1:0] rd_data1_q, rd_data1_d;
    logic [DATA_W-1:0] rd_data2_q, rd_data2_d;
    logic              rd_busy1_q, rd_busy1_d;
    logic              rd_busy2_q, rd_busy2_d;
    logic              wr_ok, rsv_ok, byp1, byp2;
    logic              rel_busy1, rel_busy2;

    // Register 0 is neither writable nor reservable when hard-wired to zero.
    assign wr_ok  = bus.wr_en  && !((ZERO_REG != 0) && (bus.wr_addr  == '0));
    assign rsv_ok = bus.rsv_en && !((ZERO_REG != 0) && (bus.rsv_addr == '0));
    assign byp1   = (BYPASS != 0) && wr_ok && (bus.wr_addr == bus.rd_addr1);
    assign byp2   = (BYPASS != 0) && wr_ok && (bus.wr_addr == bus.rd_addr2);

    rf_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_ok     (wr_ok),
        .wr_addr   (bus.wr_addr),
        .rsv_ok    (rsv_ok),
        .rsv_addr  (bus.rsv_addr),
        .rd_addr1  (bus.rd_addr1),
        .rd_addr2  (bus.rd_addr2),
        .rel_busy1 (rel_busy1),
        .rel_busy2 (rel_busy2),
        .pend_cnt  (bus.pend_cnt)
    );

    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        regs_d = regs_q;
        if (wr_ok) begin
            regs_d[bus.wr_addr] = bus.wr_data;
        end

        rd_data1_d = rd_data1_q;
        rd_data2_d = rd_data2_q;
        rd_busy1_d = rd_busy1_q;
        rd_busy2_d = rd_busy2_q;
        if (bus.rd_en) begin
            rd_data1_d = byp1 ? bus.wr_data : regs_q[bus.rd_addr1];
            rd_data2_d = byp2 ? bus.wr_data : regs_q[bus.rd_addr2];
            rd_busy1_d = rel_busy1;
            rd_busy2_d = rel_busy2;
        end
    end

    // NOTE: the array is cleared by reset on purpose (asynchronous clear of all
    // registers), so it maps to flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q     <= '{default: '0};
            rd_data1_q <= '0;
            rd_data2_q <= '0;
            rd_busy1_q <= 1'b0;
            rd_busy2_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            rd_data1_q <= rd_data1_d;
            rd_data2_q <= rd_data2_d;
            rd_busy1_q <= rd_busy1_d;
            rd_busy2_q <= rd_busy2_d;
        end
    end

    assign bus.rd_data1 = rd_data1_q;
    assign bus.rd_data2 = rd_data2_q;
    assign bus.rd_busy1 = rd_busy1_q;
    assign bus.rd_busy2 = rd_busy2_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Table-driven bench for regfile_scoreboard; a BYPASS=0 twin shares all stimulus.
module tb_regfile_scoreboard;
    import regfile_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2 ** AW;

    typedef struct {
        logic          rd_en;
        logic [AW-1:0] a1, a2;
        logic          wr_en;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          rsv_en;
        logic [AW-1:0] ra;
        logic [DW-1:0] d1, d2;
        logic          b1, b2;
        logic [AW:0]   cnt;
        logic [DW-1:0] nb1;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;
    vec_t exp_q[$];
    vec_t tbl[14];
    vec_t last;
    logic pend_m[DEPTH];

    regfile_scoreboard_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    regfile_scoreboard_if #(.DATA_W(DW), .ADDR_W(AW)) bus_nb ();

    regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_nb)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rd_en, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                                input logic wr_en, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                input logic rsv_en, input logic [AW-1:0] ra,
                                input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                                input logic b1, input logic b2, input logic [AW:0] cnt,
                                input logic [DW-1:0] nb1);
        vec_t v;
        v.rd_en = rd_en; v.a1 = a1; v.a2 = a2;
        v.wr_en = wr_en; v.wa = wa; v.wd = wd;
        v.rsv_en = rsv_en; v.ra = ra;
        v.d1 = d1; v.d2 = d2; v.b1 = b1; v.b2 = b2; v.cnt = cnt; v.nb1 = nb1;
        return v;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.rd_en = v.rd_en;     bus_nb.rd_en = v.rd_en;
        bus.rd_addr1 = v.a1;     bus_nb.rd_addr1 = v.a1;
        bus.rd_addr2 = v.a2;     bus_nb.rd_addr2 = v.a2;
        bus.wr_en = v.wr_en;     bus_nb.wr_en = v.wr_en;
        bus.wr_addr = v.wa;      bus_nb.wr_addr = v.wa;
        bus.wr_data = v.wd;      bus_nb.wr_data = v.wd;
        bus.rsv_en = v.rsv_en;   bus_nb.rsv_en = v.rsv_en;
        bus.rsv_addr = v.ra;     bus_nb.rsv_addr = v.ra;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " rd_data1"}, bus.rd_data1, '0);
        check({tag, " rd_data2"}, bus.rd_data2, '0);
        check({tag, " rd_busy1"}, DW'(bus.rd_busy1), '0);
        check({tag, " rd_busy2"}, DW'(bus.rd_busy2), '0);
        check({tag, " pend_cnt"}, DW'(bus.pend_cnt), '0);
        check({tag, " nb rd_data1"}, bus_nb.rd_data1, '0);
    endtask

    task automatic step(input string tag, input vec_t v);
        vec_t e;
        @(negedge clk);
        drive(v);
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, " rd_data1"}, bus.rd_data1, e.d1);
        check({tag, " rd_data2"}, bus.rd_data2, e.d2);
        check({tag, " rd_busy1"}, DW'(bus.rd_busy1), DW'(e.b1));
        check({tag, " rd_busy2"}, DW'(bus.rd_busy2), DW'(e.b2));
        check({tag, " pend_cnt"}, DW'(bus.pend_cnt), DW'(e.cnt));
        check({tag, " nb rd_data1"}, bus_nb.rd_data1, e.nb1);
        last = e;
    endtask

    // Model-driven step for the fill/release loops: reads are off, so outputs hold.
    task automatic model_step(input string tag, input logic wr_en, input logic [AW-1:0] wa,
                              input logic [DW-1:0] wd, input logic rsv_en, input logic [AW-1:0] ra);
        vec_t v;
        int   pop;
        pop = 0;
        for (int i = 1; i < DEPTH; i++) begin
            pend_m[i] = pend_next(pend_m[i], wr_en && (wa == AW'(i)), rsv_en && (ra == AW'(i)));
            if (pend_m[i]) pop++;
        end
        v = mk(1'b0, '0, '0, wr_en, wa, wd, rsv_en, ra,
               last.d1, last.d2, last.b1, last.b2, (AW + 1)'(pop), last.nb1);
        step(tag, v);
    endtask

    initial begin
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        tbl[0]  = mk(0, 0, 0, 1, 5, 32'hDEADBEEF, 1, 7, 0, 0, 0, 0, 1, 0);
        tbl[1]  = mk(1, 5, 7, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 1, 1, 32'hDEADBEEF);
        tbl[2]  = mk(1, 5, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 1, 3, 32'h12345678, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(1, 3, 3, 0, 0, 0, 0, 0, 32'h12345678, 32'h12345678, 0, 0, 0, 32'h12345678);
        tbl[5]  = mk(1, 9, 3, 1, 9, 32'hA5A5A5A5, 0, 0, 32'hA5A5A5A5, 32'h12345678, 0, 0, 0, 0);
        tbl[6]  = mk(1, 0, 9, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 32'hA5A5A5A5, 0, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 1, 4, 0, 32'hA5A5A5A5, 0, 0, 1, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 1, 6, 0, 32'hA5A5A5A5, 0, 0, 2, 0);
        tbl[9]  = mk(1, 4, 6, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0);
        tbl[10] = mk(1, 4, 6, 1, 4, 32'hCAFEF00D, 0, 0, 32'hCAFEF00D, 0, 0, 1, 1, 0);
        tbl[11] = mk(1, 4, 6, 1, 6, 32'h11112222, 1, 6, 32'hCAFEF00D, 32'h11112222, 0, 0, 1,
                     32'hCAFEF00D);
        tbl[12] = mk(1, 6, 4, 0, 0, 0, 0, 0, 32'h11112222, 32'hCAFEF00D, 1, 0, 1, 32'h11112222);
        tbl[13] = mk(0, 0, 0, 1, 6, 32'h33334444, 0, 0, 32'h11112222, 32'hCAFEF00D, 1, 0, 0,
                     32'h11112222);

        repeat (2) @(posedge clk);
        #1;
        check_zero("por");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            if (i == 2) begin
                // Asynchronous reset between edges, with the previous read still driven.
                @(negedge clk);
                #2;
                rst_n = 1'b0;
                #1;
                check_zero("mid_rst async");
                @(posedge clk);
                #1;
                check_zero("mid_rst held");
                @(negedge clk);
                drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                rst_n = 1'b1;
            end
            step($sformatf("vec%0d", i), tbl[i]);
        end

        for (int i = 0; i < DEPTH; i++) pend_m[i] = 1'b0;
        for (int r = 1; r < DEPTH; r++) begin
            model_step($sformatf("fill r%0d", r), 1'b0, '0, '0, 1'b1, AW'(r));
        end
        check("fill full", DW'(bus.pend_cnt), DW'(DEPTH - 1));
        model_step("re-reserve r1", 1'b0, '0, '0, 1'b1, AW'(1));
        for (int r = 1; r < DEPTH; r++) begin
            model_step($sformatf("release r%0d", r), 1'b1, AW'(r), 32'h1000_0000 | DW'(r), 1'b0, '0);
        end
        check("drained", DW'(bus.pend_cnt), '0);
        model_step("release idle r2", 1'b1, AW'(2), 32'h1000_0002, 1'b0, '0);

        step("final read", mk(1, 31, 1, 0, 0, 0, 0, 0, 32'h1000_001F, 32'h1000_0001, 0, 0, 0,
                              32'h1000_001F));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
